// File: rtl/gmii_rx.sv
// +----------------------------------------------------------------------+
// | gmii_rx : GMII receive framer with preamble strip and CRC-32 check    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module gmii_rx (
  input  logic        gmii_rx_clk,
  input  logic        sys_rst,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic [7:0]  gmii_rxd,
  input  logic        fifo_full,
  output logic        fifo_dv,
  output logic [7:0]  fifo_dout,
  output logic        fifo_sof,
  output logic        fifo_eof,
  output logic        fifo_crc_ok,
  output logic        fifo_err,
  output logic [15:0] drop_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PRE  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] DROP = 2'd3;

  localparam logic [31:0] c_crc_poly    = 32'hEDB8_8320;
  localparam logic [31:0] c_crc_residue = 32'hDEBB_20E3;
  localparam logic [10:0] c_cnt_max     = 11'h7FF;
  localparam logic [10:0] c_len_min     = 11'd64;
  localparam logic [10:0] c_len_max     = 11'd1522;

  logic [1:0]  r_state;
  logic [7:0]  r_hold;
  logic        r_held;
  logic        r_first;
  logic        r_er;
  logic [31:0] r_crc;
  logic [10:0] r_cnt;

  logic [31:0] w_crc_next;
  logic        w_len_bad;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ c_crc_poly) : (c >> 1);
    end
    return c;
  endfunction

  assign w_crc_next = crc_byte(r_crc, gmii_rxd);
  assign w_len_bad  = (r_cnt < c_len_min) || (r_cnt > c_len_max);

  always_ff @(posedge gmii_rx_clk) begin
    if (sys_rst) begin
      r_state     <= IDLE;
      r_hold      <= 8'h00;
      r_held      <= 1'b0;
      r_first     <= 1'b0;
      r_er        <= 1'b0;
      r_crc       <= 32'h0;
      r_cnt       <= 11'd0;
      fifo_dv     <= 1'b0;
      fifo_dout   <= 8'h00;
      fifo_sof    <= 1'b0;
      fifo_eof    <= 1'b0;
      fifo_crc_ok <= 1'b0;
      fifo_err    <= 1'b0;
      drop_cnt    <= 16'h0000;
    end else begin
      fifo_dv     <= 1'b0;
      fifo_sof    <= 1'b0;
      fifo_eof    <= 1'b0;
      fifo_crc_ok <= 1'b0;
      fifo_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (gmii_rx_dv && gmii_rxd == 8'h55) r_state <= PRE;
        end
        PRE: begin
          if (!gmii_rx_dv) begin
            r_state <= IDLE;
          end else if (gmii_rxd == 8'hD5) begin
            r_state <= DATA;
            r_crc   <= 32'hFFFF_FFFF;
            r_cnt   <= 11'd0;
            r_er    <= 1'b0;
            r_held  <= 1'b0;
            r_first <= 1'b1;
          end else if (gmii_rxd != 8'h55) begin
            r_state <= DROP;
          end
        end
        DATA: begin
          if (gmii_rx_dv) begin
            // A blocked write truncates the frame; the rest of it is discarded in DROP.
            if (r_held && fifo_full) begin
              drop_cnt <= drop_cnt + 16'd1;
              r_state  <= DROP;
            end else begin
              if (r_held) begin
                fifo_dv   <= 1'b1;
                fifo_dout <= r_hold;
                fifo_sof  <= r_first;
                r_first   <= 1'b0;
              end
              r_hold <= gmii_rxd;
              r_held <= 1'b1;
              r_crc  <= w_crc_next;
              if (r_cnt != c_cnt_max) r_cnt <= r_cnt + 11'd1;
              if (gmii_rx_er) r_er <= 1'b1;
            end
          end else begin
            r_state <= IDLE;
            r_held  <= 1'b0;
            if (r_held) begin
              if (fifo_full) begin
                drop_cnt <= drop_cnt + 16'd1;
                r_state  <= DROP;
              end else begin
                fifo_dv     <= 1'b1;
                fifo_dout   <= r_hold;
                fifo_sof    <= r_first;
                fifo_eof    <= 1'b1;
                fifo_crc_ok <= (r_crc == c_crc_residue);
                fifo_err    <= r_er || w_len_bad;
                r_first     <= 1'b0;
              end
            end
          end
        end
        DROP: begin
          if (!gmii_rx_dv) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/gmii_rx.md
GMII_RX -- requirements
Module: gmii_rx

Interface
REQ-001 SHALL have port gmii_rx_clk, input, 1 bit: sole clock; every register updates on its rising edge.
REQ-002 SHALL have port sys_rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port gmii_rx_dv, input, 1 bit: GMII receive data valid.
REQ-004 SHALL have port gmii_rx_er, input, 1 bit: GMII receive error.
REQ-005 SHALL have port gmii_rxd, input, 8 bits: GMII receive byte.
REQ-006 SHALL have port fifo_full, input, 1 bit: downstream FIFO cannot accept a write this cycle.
REQ-007 SHALL have port fifo_dv, output reg, 1 bit: write strobe, one byte per asserted cycle.
REQ-008 SHALL have port fifo_dout, output reg, 8 bits: frame byte, valid when fifo_dv=1.
REQ-009 SHALL have port fifo_sof, output reg, 1 bit: first byte of frame, qualified by fifo_dv.
REQ-010 SHALL have port fifo_eof, output reg, 1 bit: last byte of frame, qualified by fifo_dv.
REQ-011 SHALL have port fifo_crc_ok, output reg, 1 bit: FCS residue matched; meaningful only with fifo_eof=1.
REQ-012 SHALL have port fifo_err, output reg, 1 bit: rx_er seen or length out of range; meaningful only with fifo_eof=1.
REQ-013 SHALL have port drop_cnt, output reg, 16 bits: count of frames truncated by fifo_full; wraps from 0xFFFF to 0x0000.

Function
REQ-014 SHALL implement FSM states IDLE, PRE, DATA, DROP.
REQ-015 SHALL go IDLE->PRE when rx_dv=1 and rxd=0x55; all other IDLE inputs stay in IDLE.
REQ-016 In PRE: rxd=0x55 stays in PRE; rxd=0xD5 goes to DATA; any other byte goes to DROP; rx_dv=0 goes to IDLE.
REQ-017 DROP SHALL return to IDLE on the first cycle with rx_dv=0 and SHALL produce no writes.
REQ-018 Preamble and SFD bytes SHALL never be written to the FIFO.
REQ-019 In DATA, each rx_dv=1 byte SHALL enter a one-byte hold register; the previously held byte SHALL be written on the next cycle.
REQ-020 Latency: rxd byte N at cycle t SHALL appear on fifo_dout at cycle t+2 for non-final bytes.
REQ-021 On rx_dv falling in DATA, the held byte SHALL be written one cycle later with fifo_eof=1, and the FSM SHALL go to IDLE.
REQ-022 fifo_sof SHALL be 1 on the first written byte of each frame only; a 1-byte frame asserts sof and eof together.
REQ-023 If rx_dv falls immediately after the SFD, there SHALL be no write and no eof.
REQ-024 CRC-32 SHALL be reflected (poly 0xEDB88320, LSB first), initialised to 0xFFFFFFFF on SFD, and run over all DATA bytes including FCS.
REQ-025 fifo_crc_ok SHALL be 1 iff the final CRC register equals 0xDEBB20E3.
REQ-026 The byte counter SHALL be 11 bits and saturate at 2047.
REQ-027 fifo_err SHALL be 1 if rx_er=1 on any DATA cycle, or if the count is <64 or >1522.
REQ-028 If fifo_full=1 on a cycle where a write would occur: the byte SHALL not be written, drop_cnt SHALL increment by 1, and the FSM SHALL go to DROP (frame truncated, no eof).
REQ-029 Downstream resynchronises on fifo_sof; truncated frames SHALL carry no further marking.
REQ-030 fifo_dv, fifo_sof and fifo_eof SHALL be 0 on every cycle without a write.
REQ-031 Simultaneous rx_dv falling and fifo_full=1 SHALL follow REQ-028 (no eof written).

Reset
REQ-032 While sys_rst=1: FSM=IDLE, all outputs 0, drop_cnt=0, hold register and CRC cleared; sys_rst takes priority over all other inputs.
REQ-033 Reset mid-frame SHALL abandon the frame with no eof; a following frame SHALL be received normally.

Verification
REQ-034 7x0x55, 0xD5, bytes 0x00..0x3B, 4 valid FCS bytes -> 64 writes; first 0x00 with sof; 64th with eof, crc_ok=1, err=0.
REQ-035 Same frame with byte 0x10 changed to 0xFF -> 64 writes; eof with crc_ok=0.
REQ-036 0x55, 0x55, 0xAA, then 10 bytes, rx_dv low -> zero writes; FSM back in IDLE.
REQ-037 Valid 64-byte frame with rx_er=1 on byte 20 -> 64 writes; eof with err=1.
REQ-038 fifo_full=1 on the cycle the 10th byte would be written -> 9 writes, no eof, drop_cnt=1; the next frame is received intact.
REQ-039 sys_rst pulsed at data byte 30 -> all outputs 0 next cycle, drop_cnt=0; the following valid frame is received with crc_ok=1.
